// File: rtl/fp_div_seq_if.sv
// Handshake and operand/result bundle for the sequential FP divider.
interface fp_div_seq_if;
    logic        start;
    logic [31:0] N1;
    logic [31:0] N2;
    logic [31:0] Result;
    logic        done;
    logic        busy;
    logic        div_by_zero;

    modport master (output start, N1, N2, input Result, done, busy, div_by_zero);
    modport slave  (input start, N1, N2, output Result, done, busy, div_by_zero);
endinterface

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division,
// truncating, denormals flushed to zero, start/busy/done handshake.
module fp_div_seq #(
    parameter int ITER     = 25,
    parameter int EXP_BIAS = 127
) (
    input  logic         clk,
    input  logic         reset,
    fp_div_seq_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, CHECK, DIV, NORM, DONE} state_t;

    localparam logic [4:0]        LAST_ITER = 5'(ITER - 1);
    localparam logic signed [9:0] BIAS      = 10'(EXP_BIAS);

    state_t      state_q, state_d;
    logic [31:0] a_q, b_q;
    logic [24:0] rem_q, q_q;
    logic [4:0]  cnt_q;
    logic [31:0] res_q, result_q;
    logic        dbz_q, dbz_out_q, done_q;

    logic        sign;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        special, special_dbz;
    logic [31:0] special_res;
    logic [24:0] divisor, diff, rem_next;
    logic        q_bit;
    logic signed [9:0] exp_raw, exp_adj;
    logic [22:0] frac;
    logic [31:0] norm_res;

    assign bus.Result      = result_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_out_q;
    assign bus.busy        = (state_q != IDLE);

    // Operand classification; a zero exponent counts as zero whatever the fraction.
    always_comb begin
        sign        = a_q[31] ^ b_q[31];
        a_zero      = (a_q[30:23] == 8'd0);
        b_zero      = (b_q[30:23] == 8'd0);
        a_inf       = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf       = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan       = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan       = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        special     = 1'b1;
        special_dbz = 1'b0;
        special_res = 32'd0;
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            special_res = 32'h7FC00000;
        end else if (a_inf) begin
            special_res = {sign, 31'h7F800000};
        end else if (b_inf || a_zero) begin
            special_res = {sign, 31'd0};
        end else if (b_zero) begin
            special_res = {sign, 31'h7F800000};
            special_dbz = 1'b1;
        end else begin
            special = 1'b0;
        end
    end

    // One restoring step: subtract when the partial remainder covers the divisor.
    always_comb begin
        divisor  = {2'b01, b_q[22:0]};
        q_bit    = (rem_q >= divisor);
        diff     = rem_q - divisor;
        rem_next = q_bit ? {diff[23:0], 1'b0} : {rem_q[23:0], 1'b0};
    end

    always_comb begin
        exp_raw  = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + BIAS;
        exp_adj  = q_q[24] ? exp_raw : exp_raw - 10'sd1;
        frac     = q_q[24] ? q_q[23:1] : q_q[22:0];
        norm_res = {sign, exp_adj[7:0], frac};
        if (exp_adj >= 10'sd255) begin
            norm_res = {sign, 31'h7F800000};
        end else if (exp_adj <= 10'sd0) begin
            norm_res = {sign, 31'd0};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CHECK;
            CHECK:   state_d = special ? DONE : DIV;
            DIV:     if (cnt_q == LAST_ITER) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result and done are registered on leaving DONE, so done shows in the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            rem_q     <= 25'd0;
            q_q       <= 25'd0;
            cnt_q     <= 5'd0;
            res_q     <= 32'd0;
            dbz_q     <= 1'b0;
            result_q  <= 32'd0;
            dbz_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q       <= bus.N1;
                        b_q       <= bus.N2;
                        dbz_out_q <= 1'b0;
                    end
                end
                CHECK: begin
                    rem_q <= {2'b01, a_q[22:0]};
                    q_q   <= 25'd0;
                    cnt_q <= 5'd0;
                    res_q <= special_res;
                    dbz_q <= special_dbz;
                end
                DIV: begin
                    rem_q <= rem_next;
                    q_q   <= {q_q[23:0], q_bit};
                    cnt_q <= cnt_q + 5'd1;
                end
                NORM: begin
                    res_q <= norm_res;
                    dbz_q <= 1'b0;
                end
                DONE: begin
                    result_q  <= res_q;
                    dbz_out_q <= dbz_q;
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed and randomized checks of fp_div_seq against an arithmetic reference model.
module tb_fp_div_seq;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    fp_div_seq_if bus ();

    fp_div_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: quotient as floor(ma * 2^24 / mb), then normalise with plain integers.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic dbz, output logic spec);
        logic   s;
        int     ea, eb, e;
        longint ma, mb, q, fr;
        s    = a[31] ^ b[31];
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        dbz  = 1'b0;
        spec = 1'b1;
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
            (ea == 255 && eb == 255) || (ea == 0 && eb == 0)) begin
            r = 32'h7FC00000;
        end else if (ea == 255) begin
            r = {s, 31'h7F800000};
        end else if (eb == 255 || ea == 0) begin
            r = {s, 31'd0};
        end else if (eb == 0) begin
            r   = {s, 31'h7F800000};
            dbz = 1'b1;
        end else begin
            spec = 1'b0;
            ma   = 64'h800000 + longint'(a[22:0]);
            mb   = 64'h800000 + longint'(b[22:0]);
            q    = (ma * 64'h1000000) / mb;
            e    = ea - eb + 127;
            if (q >= 64'h1000000) begin
                fr = (q / 2) % 64'h800000;
            end else begin
                fr = q % 64'h800000;
                e  = e - 1;
            end
            if (e >= 255)     r = {s, 31'h7F800000};
            else if (e <= 0)  r = {s, 31'd0};
            else              r = {s, 8'(e), 23'(fr)};
        end
    endfunction

    function automatic logic [31:0] randOperand();
        int          cls;
        logic [31:0] v;
        cls = int'($urandom_range(0, 11));
        v   = $urandom;
        if (cls == 0)      v[30:23] = 8'd0;
        else if (cls == 1) begin
            v[30:23] = 8'hFF;
            if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0;
        end else           v[30:23] = 8'($urandom_range(1, 254));
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output int busy_cnt);
        int guard;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.N1    = a;
        bus.N2    = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.N1    = $urandom;
        bus.N2    = $urandom;
        busy_cnt  = 0;
        lat       = -1;
        for (int k = 1; k <= 60; k++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic exp_dbz, input int exp_lat);
        int lat, busy_cnt;
        applyStimulus(a, b, lat, busy_cnt);
        checkOutput({tag, " result"}, bus.Result, exp_r);
        checkOutput({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(exp_dbz));
        checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
    endtask

    initial begin
        logic [31:0] a, b, r;
        logic        dbz, spec;
        int          pulses;
        logic [31:0] captured;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.N1      = 32'd0;
        bus.N2      = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset Result", bus.Result, 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset dbz", 32'(bus.div_by_zero), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        runOp("6/2",      32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28);
        runOp("1/3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 28);
        runOp("-1/0.5",   32'hBF800000, 32'h3F000000, 32'hC0000000, 1'b0, 28);
        runOp("1/0",      32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 2);
        runOp("0/0",      32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 2);
        runOp("inf/inf",  32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 2);
        runOp("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 28);
        runOp("underflow",32'h00800000, 32'h4B000000, 32'h00000000, 1'b0, 28);

        // Second start arrives while busy and must be dropped.
        repeat (3) @(posedge clk);
        #1;
        bus.N1 = 32'h40C00000; bus.N2 = 32'h40000000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus.N1 = 32'h3F800000; bus.N2 = 32'h40400000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        pulses   = 0;
        captured = 32'hDEADBEEF;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                pulses++;
                captured = bus.Result;
            end
        end
        checkOutput("ignored start pulses", 32'(pulses), 32'd1);
        checkOutput("ignored start result", captured, 32'h40400000);

        // Reset ten cycles into an operation aborts it without a done.
        bus.N1 = 32'h40C00000; bus.N2 = 32'h40000000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort done", 32'(bus.done), 32'd0);
        checkOutput("abort Result", bus.Result, 32'd0);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) pulses++;
        end
        checkOutput("abort no done", 32'(pulses), 32'd0);
        runOp("after abort", 32'hBF800000, 32'h3F000000, 32'hC0000000, 1'b0, 28);

        for (int i = 0; i < 24; i++) begin
            a = randOperand();
            b = randOperand();
            model(a, b, r, dbz, spec);
            runOp($sformatf("rand%0d %h/%h", i, a, b), a, b, r, dbz, spec ? 2 : 28);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
